// File: rtl/muldiv_unit.sv
// Iterative MIPS mult/multu/div/divu unit owning HI/LO; radix-2 shift-add multiply, restoring divide.
// Latency WIDTH+2 edges from accept to done; busy blocks new issue and mthi/mtlo, start while busy is dropped.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  logic [1:0]         state;
  logic [CW-1:0]      cnt;
  logic [1:0]         op_r;
  logic [WIDTH-1:0]   mreg;
  logic [WIDTH-1:0]   a_r;
  logic [2*WIDTH-1:0] p;
  logic               neg_lo;
  logic               neg_hi;
  logic               bzero;

  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_trial;
  logic [2*WIDTH-1:0] div_next;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  assign busy  = (state != S_IDLE);
  assign a_neg = ~op[0] & a[WIDTH-1];
  assign b_neg = ~op[0] & b[WIDTH-1];
  assign a_mag = a_neg ? -a : a;
  assign b_mag = b_neg ? -b : b;

  // Multiply: p = {partial sum, remaining multiplier bits}, mreg = multiplicand.
  assign mul_sum  = {1'b0, p[2*WIDTH-1:WIDTH]} + {1'b0, (p[0] ? mreg : {WIDTH{1'b0}})};
  assign mul_next = {mul_sum, p[WIDTH-1:1]};

  // Divide: p = {partial remainder, dividend/quotient}, mreg = divisor.
  assign div_shift = {p[2*WIDTH-1:WIDTH], p[WIDTH-1]};
  assign div_trial = div_shift - {1'b0, mreg};
  assign div_next  = div_trial[WIDTH] ? {div_shift[WIDTH-1:0], p[WIDTH-2:0], 1'b0}
                                      : {div_trial[WIDTH-1:0], p[WIDTH-2:0], 1'b1};

  assign prod_fix = neg_lo ? -p : p;
  assign quo_fix  = neg_lo ? -p[WIDTH-1:0] : p[WIDTH-1:0];
  assign rem_fix  = neg_hi ? -p[2*WIDTH-1:WIDTH] : p[2*WIDTH-1:WIDTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_IDLE;
      cnt    <= '0;
      op_r   <= '0;
      mreg   <= '0;
      a_r    <= '0;
      p      <= '0;
      neg_lo <= 1'b0;
      neg_hi <= 1'b0;
      bzero  <= 1'b0;
      done   <= 1'b0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (hi_we) hi <= wdata;
          if (lo_we) lo <= wdata;
          if (start && !flush) begin
            op_r   <= op;
            a_r    <= a;
            bzero  <= (b == '0);
            neg_lo <= a_neg ^ b_neg;
            neg_hi <= a_neg;
            cnt    <= '0;
            state  <= S_CALC;
            if (op[1]) begin
              mreg <= b_mag;
              p    <= {{WIDTH{1'b0}}, a_mag};
            end else begin
              mreg <= a_mag;
              p    <= {{WIDTH{1'b0}}, b_mag};
            end
          end
        end
        S_CALC: begin
          if (flush) begin
            state <= S_IDLE;
          end else begin
            p   <= op_r[1] ? div_next : mul_next;
            cnt <= cnt + 1'b1;
            if (cnt == CW'(WIDTH - 1)) state <= S_FIX;
          end
        end
        S_FIX: begin
          state <= S_IDLE;
          if (!flush) begin
            done <= 1'b1;
            if (!op_r[1]) begin
              hi <= prod_fix[2*WIDTH-1:WIDTH];
              lo <= prod_fix[WIDTH-1:0];
            end else if (bzero) begin
              hi <= a_r;
              lo <= '1;
            end else begin
              hi <= rem_fix;
              lo <= quo_fix;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed vectors, randomized ops vs an arithmetic model, flush/reset/mthi/mtlo, WIDTH=8 back-to-back.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, flush, hi_we, lo_we;
  logic [1:0]  op;
  logic [31:0] a, b, wdata;
  logic        busy, done;
  logic [31:0] hi, lo;

  logic        start8, flush8, hi_we8, lo_we8;
  logic [1:0]  op8;
  logic [7:0]  a8, b8, wdata8;
  logic        busy8, done8;
  logic [7:0]  hi8, lo8;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b), .flush(flush),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  muldiv_unit #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .op(op8), .a(a8), .b(b8), .flush(flush8),
    .hi_we(hi_we8), .lo_we(lo_we8), .wdata(wdata8), .busy(busy8), .done(done8), .hi(hi8), .lo(lo8)
  );

  // Reference: MIPS HI/LO semantics from plain integer arithmetic at width w.
  function automatic void model(input int w, input logic [1:0] o, input logic [31:0] x, y,
                                output logic [31:0] mhi, output logic [31:0] mlo);
    logic [63:0] mask, ux, uy, pr;
    longint sx, sy, q, r;
    mask = (64'd1 << w) - 64'd1;
    ux = {32'd0, x} & mask;
    uy = {32'd0, y} & mask;
    sx = x[w-1] ? longint'(ux) - (longint'(1) << w) : longint'(ux);
    sy = y[w-1] ? longint'(uy) - (longint'(1) << w) : longint'(uy);
    mhi = '0;
    mlo = '0;
    case (o)
      2'd0, 2'd1: begin
        pr  = (o == 2'd0) ? 64'(sx * sy) : ux * uy;
        mlo = 32'(pr & mask);
        mhi = 32'((pr >> w) & mask);
      end
      default: begin
        if (uy == 64'd0) begin
          mhi = 32'(ux);
          mlo = 32'(mask);
        end else if (o == 2'd2) begin
          q = sx / sy;
          r = sx % sy;
          mlo = 32'(q & longint'(mask));
          mhi = 32'(r & longint'(mask));
        end else begin
          mlo = 32'(ux / uy);
          mhi = 32'(ux % uy);
        end
      end
    endcase
  endfunction

  // Called #1 after an edge with the unit idle (or in its done cycle); returns cycles from accept to done.
  task automatic issue32(input logic [1:0] o, input logic [31:0] x, y,
                         output int lat, output logic busy_acc, output logic busy_done);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0; op = 2'($urandom); a = $urandom; b = $urandom;
    busy_acc = busy;
    lat = 0;
    while (done !== 1'b1 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    busy_done = busy;
  endtask

  task automatic issue8(input logic [1:0] o, input logic [7:0] x, y, output int lat);
    start8 = 1'b1; op8 = o; a8 = x; b8 = y;
    @(posedge clk); #1;
    start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
    lat = 0;
    while (done8 !== 1'b1 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if ({busy, done, hi, lo} !== 66'd0) begin
      n_fail++;
      $display("FAIL reset32: busy=%b done=%b hi=%h lo=%h, required all zero", busy, done, hi, lo);
    end
    n_tests++;
    if ({busy8, done8, hi8, lo8} !== 18'd0) begin
      n_fail++;
      $display("FAIL reset8: busy=%b done=%b hi=%h lo=%h, required all zero", busy8, done8, hi8, lo8);
    end
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_directed;
    logic [1:0]  ops [5]  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd2};
    logic [31:0] xs  [5]  = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFF9, 32'h00000064, 32'h80000000};
    logic [31:0] ys  [5]  = '{32'h00000007, 32'hFFFFFFFF, 32'h00000002, 32'h00000000, 32'hFFFFFFFF};
    logic [31:0] ehi [5]  = '{32'hFFFFFFFF, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000064, 32'h00000000};
    logic [31:0] elo [5]  = '{32'hFFFFFFEB, 32'h00000001, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'h80000000};
    int lat;
    logic ba, bd;
    for (int i = 0; i < 5; i++) begin
      issue32(ops[i], xs[i], ys[i], lat, ba, bd);
      n_tests++;
      if (lat !== 33 || ba !== 1'b1 || bd !== 1'b0) begin
        n_fail++;
        $display("FAIL directed%0d timing: lat=%0d busy_acc=%b busy_done=%b, required 33/1/0", i, lat, ba, bd);
      end
      n_tests++;
      if (hi !== ehi[i] || lo !== elo[i]) begin
        n_fail++;
        $display("FAIL directed%0d result: hi=%h lo=%h, required hi=%h lo=%h", i, hi, lo, ehi[i], elo[i]);
      end
    end
    @(posedge clk); #1;
    n_tests++;
    if (done !== 1'b0) begin
      n_fail++;
      $display("FAIL done_pulse: done=%b one cycle later, required 0", done);
    end
  endtask

  task automatic test_random;
    logic [1:0]  o;
    logic [31:0] x, y, mhi, mlo;
    int lat;
    logic ba, bd;
    for (int i = 0; i < 30; i++) begin
      o = 2'($urandom_range(0, 3));
      x = $urandom;
      y = $urandom;
      case ($urandom_range(0, 5))
        0: y = 32'($urandom_range(0, 3));
        1: y = 32'hFFFFFFFF;
        2: x = 32'h80000000;
        3: y = 32'($urandom_range(1, 300));
        default: ;
      endcase
      model(32, o, x, y, mhi, mlo);
      issue32(o, x, y, lat, ba, bd);
      n_tests++;
      if (hi !== mhi || lo !== mlo || lat !== 33) begin
        n_fail++;
        $display("FAIL random%0d op=%0d a=%h b=%h: hi=%h lo=%h lat=%0d, required hi=%h lo=%h lat=33",
                 i, o, x, y, hi, lo, lat, mhi, mlo);
      end
    end
  endtask

  task automatic test_ignore_start;
    logic [31:0] mhi, mlo;
    int ndone = 0;
    int lat = 0;
    model(32, 2'd0, 32'h00001234, 32'hFFFF0003, mhi, mlo);
    start = 1'b1; op = 2'd0; a = 32'h00001234; b = 32'hFFFF0003;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    start = 1'b1; op = 2'd3; a = 32'h00000777; b = 32'h00000005;
    @(posedge clk); #1;
    start = 1'b0;
    while (lat < 60) begin
      if (done === 1'b1) ndone++;
      @(posedge clk); #1;
      lat++;
    end
    n_tests++;
    if (ndone !== 1 || hi !== mhi || lo !== mlo || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL ignore_start: dones=%0d hi=%h lo=%h busy=%b, required 1 %h %h 0", ndone, hi, lo, busy, mhi, mlo);
    end
  endtask

  task automatic test_flush_reset;
    int ndone;
    hi_we = 1'b1; wdata = 32'h11111111;
    @(posedge clk); #1;
    hi_we = 1'b0; lo_we = 1'b1; wdata = 32'h22222222;
    @(posedge clk); #1;
    lo_we = 1'b0;
    n_tests++;
    if (hi !== 32'h11111111 || lo !== 32'h22222222) begin
      n_fail++;
      $display("FAIL preload: hi=%h lo=%h, required 11111111 22222222", hi, lo);
    end
    start = 1'b1; op = 2'd0; a = 32'd12345; b = 32'd678;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      if (done === 1'b1) ndone++;
      @(posedge clk); #1;
    end
    n_tests++;
    if (ndone !== 0 || busy !== 1'b0 || hi !== 32'h11111111 || lo !== 32'h22222222) begin
      n_fail++;
      $display("FAIL flush: dones=%0d busy=%b hi=%h lo=%h, required 0 0 11111111 22222222", ndone, busy, hi, lo);
    end
    start = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_start_idle: busy=%b, required 0", busy);
    end
    start = 1'b1; op = 2'd2; a = 32'd1000; b = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      if (done === 1'b1) ndone++;
      @(posedge clk); #1;
    end
    n_tests++;
    if (ndone !== 0 || busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_midop: dones=%0d busy=%b hi=%h lo=%h, required 0 0 0 0", ndone, busy, hi, lo);
    end
  endtask

  task automatic test_mthi_mtlo;
    logic [31:0] mhi, mlo, lo_before;
    int lat = 0;
    model(32, 2'd3, 32'd1000, 32'd7, mhi, mlo);
    hi_we = 1'b1; wdata = 32'hA5A5A5A5;
    start = 1'b1; op = 2'd3; a = 32'd1000; b = 32'd7;
    @(posedge clk); #1;
    hi_we = 1'b0; start = 1'b0;
    n_tests++;
    if (hi !== 32'hA5A5A5A5 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL write_with_start: hi=%h busy=%b, required a5a5a5a5 1", hi, busy);
    end
    lo_before = lo;
    lo_we = 1'b1; wdata = 32'hDEADBEEF;
    @(posedge clk); #1;
    lo_we = 1'b0;
    n_tests++;
    if (lo !== lo_before) begin
      n_fail++;
      $display("FAIL write_while_busy: lo=%h, required %h", lo, lo_before);
    end
    while (done !== 1'b1 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    n_tests++;
    if (hi !== mhi || lo !== mlo) begin
      n_fail++;
      $display("FAIL result_overwrites: hi=%h lo=%h, required %h %h", hi, lo, mhi, mlo);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] mhi, mlo;
    int lat;
    issue8(2'd0, 8'h7F, 8'h80, lat);
    n_tests++;
    if (lat !== 9 || hi8 !== 8'hC0 || lo8 !== 8'h80 || busy8 !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_mult8: lat=%0d hi=%h lo=%h busy=%b, required 9 c0 80 0", lat, hi8, lo8, busy8);
    end
    issue8(2'd3, 8'hFF, 8'h10, lat);
    n_tests++;
    if (lat !== 9 || hi8 !== 8'h0F || lo8 !== 8'h0F) begin
      n_fail++;
      $display("FAIL b2b_divu8: lat=%0d hi=%h lo=%h, required 9 0f 0f", lat, hi8, lo8);
    end
    for (int i = 0; i < 12; i++) begin
      logic [1:0] o;
      logic [7:0] x, y;
      o = 2'($urandom_range(0, 3));
      x = 8'($urandom);
      y = (i % 4 == 0) ? 8'h00 : 8'($urandom);
      model(8, o, {24'd0, x}, {24'd0, y}, mhi, mlo);
      issue8(o, x, y, lat);
      n_tests++;
      if (lat !== 9 || hi8 !== mhi[7:0] || lo8 !== mlo[7:0]) begin
        n_fail++;
        $display("FAIL b2b_rand8_%0d op=%0d a=%h b=%h: lat=%0d hi=%h lo=%h, required 9 %h %h",
                 i, o, x, y, lat, hi8, lo8, mhi[7:0], mlo[7:0]);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0; flush = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    op = '0; a = '0; b = '0; wdata = '0;
    start8 = 1'b0; flush8 = 1'b0; hi_we8 = 1'b0; lo_we8 = 1'b0;
    op8 = '0; a8 = '0; b8 = '0; wdata8 = '0;
    #1;
    test_reset;
    test_directed;
    test_random;
    test_ignore_start;
    test_flush_reset;
    test_mthi_mtlo;
    test_back_to_back;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
